maquina_programada: RTL and testbench
=====================================

Name: maquina_programada

Overview:
Two-floor elevator controller for the ascensor design, implemented as a 4-state Moore FSM.
- in1/in2 are floor-1/floor-2 call requests.
- out1/out2 drive the motor up/down.
- state1/state2 expose the 2-bit state register for status LEDs and debug.
- Sits between the debounced call-button logic and the motor driver.

Parameters:
TRAVEL_CYCLES, 2, clock cycles spent in a moving state before arriving (legal range 1..255).

Ports:
clk     input  1  system clock; all state changes on rising edge
rst     input  1  asynchronous, active-high reset
in1     input  1  call request for floor 1 (level, sampled each rising edge)
in2     input  1  call request for floor 2 (level, sampled each rising edge)
state1  output 1  state[0] (LSB of state register)
state2  output 1  state[1] (MSB of state register)
out1    output 1  motor up command
out2    output 1  motor down command

Behaviour:
- Internal register state[1:0]. Encoding:
  - F1 = 2'b00: parked at floor 1
  - UP = 2'b01: moving up
  - F2 = 2'b10: parked at floor 2
  - DN = 2'b11: moving down
- Internal travel counter cnt, 8 bits.
- Reset: on rst=1, immediately (asynchronously) state=F1 and cnt=0. Therefore state1=0, state2=0, out1=0, out2=0. While rst is held, the block stays in F1.
- Outputs are Moore, decoded from the state register only; no input-to-output combinational path.
  - state1 = state[0]; state2 = state[1].
  - out1 = 1 only in UP.
  - out2 = 1 only in DN.
  - out1 and out2 are never both 1.
- Transitions (rising edge, rst=0):
  - F1: (in1,in2)=(0,1) -> UP, cnt<=0. Any other input (00, 10, 11) -> stay F1.
  - UP: inputs ignored. If cnt==TRAVEL_CYCLES-1 -> F2, cnt<=0; else cnt<=cnt+1.
  - F2: (in1,in2)=(1,0) -> DN, cnt<=0. Any other input -> stay F2.
  - DN: inputs ignored. If cnt==TRAVEL_CYCLES-1 -> F1, cnt<=0; else cnt<=cnt+1.
- Latency:
  - Request to motor-on: 1 edge.
  - Motor-on duration: exactly TRAVEL_CYCLES cycles.
  - Arrival is followed by a parked state of at least 1 cycle before any new move.
- Simultaneous in1=in2=1: treated as conflict; no movement in either parked state.
- A request for the current floor is a no-op.
- Requests arriving during motion are not queued. A request still held on arrival is evaluated normally in the parked state.
- Reset mid-travel: aborts the move; motor outputs drop to 0 asynchronously; state returns to F1.
- Before the first reset the state is undefined; the system must assert rst at power-up.
- cnt never exceeds TRAVEL_CYCLES-1; no wrap-around is possible.

Test Plan:
1. Reset: rst=1 with arbitrary inputs, then release -> state2,state1=00, out1=0, out2=0. Outputs are 00 before the next clock edge after rst rises.
2. Up trip, TRAVEL_CYCLES=2, from F1, in1=0 in2=1:
   - edge 1 -> state=01, out1=1, out2=0.
   - out1 held for 2 cycles, then state=10, out1=0.
   - in2 kept high -> remains 10.
3. Down trip from F2, in1=1 in2=0:
   - next edge -> state=11, out2=1 for 2 cycles.
   - then state=00, outputs 00.
   - in1 kept high -> remains 00.
4. Conflict/no-op:
   - in1=1 in2=1 in F1 for 6 cycles -> state 00, outputs 00.
   - Same in F2 -> stays 10.
   - in1=0 in2=0 -> no change.
   - in1=1 at F1 -> no change.
5. Ignore during travel and reset mid-travel:
   - Start UP, toggle in1 and in2 during travel -> trip completes to 10 on schedule.
   - Start a new UP, assert rst mid-travel -> asynchronously 00, out1=0.
6. Sequence at 40 ns clock, 250 ns phases, after initial reset: (0,1) (1,0) (1,1) (0,0) -> ends in F1 (00) with outputs 00; out1 and out2 never simultaneously high.

Source files
------------

// File: rtl/maquina_programada.sv
// Two-floor elevator controller: Moore FSM with a travel timer for each move.
// Outputs are decoded from the state register only.
//
// state | meaning
// F1    | parked at floor 1, motor off
// UP    | moving up, motor up on
// F2    | parked at floor 2, motor off
// DN    | moving down, motor down on
module maquina_programada #(
  parameter int TRAVEL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  output logic state1,
  output logic state2,
  output logic out1,
  output logic out2
);

  typedef enum logic [1:0] {
    F1 = 2'b00,
    UP = 2'b01,
    F2 = 2'b10,
    DN = 2'b11
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TRAVEL_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= F1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Only a single unambiguous call for the other floor starts a move;
  // inputs are ignored while travelling.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      F1: begin
        if (!in1 && in2) begin
          state_nx = UP;
          cnt_nx   = '0;
        end
      end
      UP: begin
        if (cnt == CNT_LAST) begin
          state_nx = F2;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      F2: begin
        if (in1 && !in2) begin
          state_nx = DN;
          cnt_nx   = '0;
        end
      end
      DN: begin
        if (cnt == CNT_LAST) begin
          state_nx = F1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = F1;
        cnt_nx   = '0;
      end
    endcase
  end

  assign state1 = state[0];
  assign state2 = state[1];
  assign out1   = (state == UP);
  assign out2   = (state == DN);

endmodule

// File: tb/tb_maquina_programada.sv
// Bench for maquina_programada: a floor/trip model checked every cycle,
// directed trips with literal expectations, then randomized calls and resets.
module tb_maquina_programada;

  localparam int T = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in1 = 1'b0;
  logic in2 = 1'b0;
  logic state1, state2, out1, out2;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // model: where the car is parked, where it is heading, cycles left to travel
  int floor_m = 1;
  int dest_m  = 1;
  int rem_m   = 0;

  maquina_programada #(.TRAVEL_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2),
    .state1(state1), .state2(state2), .out1(out1), .out2(out2)
  );

  always #20 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      floor_m = 1; dest_m = 1; rem_m = 0;
    end else if (rem_m > 0) begin
      rem_m = rem_m - 1;
      if (rem_m == 0) floor_m = dest_m;
    end else if (floor_m == 1 && !in1 && in2) begin
      dest_m = 2; rem_m = T;
    end else if (floor_m == 2 && in1 && !in2) begin
      dest_m = 1; rem_m = T;
    end
  end

  // packed as {state2, state1, out1, out2}
  function automatic logic [3:0] model_out();
    if (rem_m > 0) return (dest_m == 2) ? 4'b0110 : 4'b1101;
    return (floor_m == 1) ? 4'b0000 : 4'b1000;
  endfunction

  function automatic logic [3:0] dut_out();
    return {state2, state1, out1, out2};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model", dut_out(), model_out());
      chk("excl", {3'b000, out1 & out2}, 4'b0000);
    end
  end

  task automatic set_in(input logic a, input logic b);
    @(posedge clk); #5;
    in1 = a; in2 = b;
  endtask

  task automatic nchk(input string name, input logic [3:0] exp);
    @(negedge clk);
    chk(name, dut_out(), exp);
  endtask

  task automatic travel(input logic a, input logic b);
    set_in(a, b);
    repeat (T + 2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    // reset with arbitrary inputs
    #1;
    chk("rst_async", dut_out(), 4'b0000);
    in1 = 1'b1; in2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold", dut_out(), 4'b0000);
    @(posedge clk); #5;
    rst = 1'b0; in1 = 1'b0; in2 = 1'b0;
    armed = 1'b1;
    nchk("rst_rel", 4'b0000);

    // up trip, in2 held after arrival
    set_in(1'b0, 1'b1);
    nchk("up_pre", 4'b0000);
    nchk("up_1", 4'b0110);
    nchk("up_2", 4'b0110);
    nchk("up_arr", 4'b1000);
    nchk("up_hold", 4'b1000);

    // down trip, in1 held after arrival
    set_in(1'b1, 1'b0);
    nchk("dn_pre", 4'b1000);
    nchk("dn_1", 4'b1101);
    nchk("dn_2", 4'b1101);
    nchk("dn_arr", 4'b0000);
    nchk("dn_hold", 4'b0000);

    // conflicts and no-ops
    set_in(1'b1, 1'b1);
    repeat (6) nchk("conf_f1", 4'b0000);
    travel(1'b0, 1'b1);
    set_in(1'b1, 1'b1);
    repeat (6) nchk("conf_f2", 4'b1000);
    set_in(1'b0, 1'b0);
    repeat (2) nchk("idle_f2", 4'b1000);
    set_in(1'b0, 1'b1);
    repeat (2) nchk("same_f2", 4'b1000);
    travel(1'b1, 1'b0);
    set_in(1'b1, 1'b0);
    repeat (2) nchk("same_f1", 4'b0000);

    // inputs toggled during travel are ignored
    set_in(1'b0, 1'b1);
    nchk("tog_pre", 4'b0000);
    set_in(1'b1, 1'b0);
    nchk("tog_1", 4'b0110);
    set_in(1'b1, 1'b1);
    nchk("tog_2", 4'b0110);
    set_in(1'b0, 1'b0);
    nchk("tog_arr", 4'b1000);
    travel(1'b1, 1'b0);
    set_in(1'b0, 1'b0);
    nchk("back_f1", 4'b0000);

    // reset mid-travel drops the motor without waiting for a clock
    set_in(1'b0, 1'b1);
    @(posedge clk); #5;
    chk("mid_up", dut_out(), 4'b0110);
    rst = 1'b1;
    #1;
    chk("mid_rst", dut_out(), 4'b0000);
    @(posedge clk); #5;
    rst = 1'b0; in1 = 1'b0; in2 = 1'b0;
    nchk("mid_rel", 4'b0000);

    // 250 ns phases, not aligned to the clock
    @(posedge clk); #5;
    in1 = 1'b0; in2 = 1'b1; #250;
    in1 = 1'b1; in2 = 1'b0; #250;
    in1 = 1'b1; in2 = 1'b1; #250;
    in1 = 1'b0; in2 = 1'b0; #250;
    nchk("phase_end", 4'b0000);

    // randomized calls with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #5;
      in1 = 1'($urandom_range(0, 1));
      in2 = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #5;
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
